tib_loader: RTL and testbench

- Upstream stage of the outer interpreter.
- Accepts a byte stream from the UART receiver and edits it into a line in the terminal input buffer (TIB) in 8-bit memory.
- On CR/LF it writes a 0x00 terminator and raises `ready`. The top level uses `ready` as the outer interpreter enable.
- It holds the line until the outer interpreter signals `done`, then re-arms for the next line.

---
 rtl/forthsuper_pkg.sv | 38 +++
 rtl/tib_loader.sv | 165 ++++++++++++++++
 tb/tb_tib_loader.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/forthsuper_pkg.sv
// Shared definitions for the forthsuper outer interpreter front end:
// ASCII constants, TIB loader state enum and the input byte classifier.
package forthsuper_pkg;

    localparam logic [7:0] ASC_BS  = 8'h08;
    localparam logic [7:0] ASC_TAB = 8'h09;
    localparam logic [7:0] ASC_LF  = 8'h0A;
    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_SP  = 8'h20;
    localparam logic [7:0] ASC_DEL = 8'h7F;

    typedef enum logic [1:0] {ACC, TRM, RDY} tib_sts;

    typedef enum logic [1:0] {CH_PUT, CH_DEL, CH_EOL, CH_IGN} ch_cls;

    typedef struct packed {
        ch_cls      cls;
        logic [7:0] ch;   // byte to store/echo (TAB already mapped to space)
    } ch_info;

    function automatic ch_info tib_classify(input logic [7:0] b);
        ch_info r;
        r.cls = CH_IGN;
        r.ch  = b;
        if (b == ASC_TAB) begin
            r.cls = CH_PUT;
            r.ch  = ASC_SP;
        end else if (b >= ASC_SP && b < ASC_DEL) begin
            r.cls = CH_PUT;
        end else if (b == ASC_BS || b == ASC_DEL) begin
            r.cls = CH_DEL;
        end else if (b == ASC_CR || b == ASC_LF) begin
            r.cls = CH_EOL;
        end
        return r;
    endfunction

endpackage

// File: rtl/tib_loader.sv
// Line editor feeding the terminal input buffer; raises ready on a terminated line.
// Optional echo path to the UART transmitter when TIB_ECHO_EN is defined.
module tib_loader
    import forthsuper_pkg::*;
#(
    parameter int TIB    = 'h0,
    parameter int TIB_SZ = 80,
    parameter int MSZ    = 8,
    parameter int ASZ    = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_vld,
    input  logic [7:0]                rx_ch,
    output logic                      rx_rdy,
    output logic                      mem_we,
    output logic [ASZ-1:0]            mem_ai,
    output logic [MSZ-1:0]            mem_vi,
    output logic                      ready,
    input  logic                      done,
    output logic [$clog2(TIB_SZ)-1:0] len,
    output logic                      ovf
`ifdef TIB_ECHO_EN
    ,
    input  logic                      tx_rdy,
    output logic                      tx_vld,
    output logic [7:0]                tx_ch
`endif
);

    localparam int               LW      = $clog2(TIB_SZ);
    localparam logic [LW-1:0]    LEN_MAX = LW'(TIB_SZ - 1);
    localparam logic [ASZ-1:0]   TIB_A   = ASZ'(TIB);

    tib_sts         st, st_d;
    logic [LW-1:0]  len_d;
    logic           ovf_d, we_d, ready_d, rdy_d, rx_rdy_q, acc;
    logic [ASZ-1:0] ai_d;
    logic [MSZ-1:0] vi_d;
    ch_info         ci;
`ifdef TIB_ECHO_EN
    logic           tx_vld_d;
    logic [7:0]     tx_ch_d;

    assign rx_rdy = rx_rdy_q & tx_rdy;
`else
    assign rx_rdy = rx_rdy_q;
`endif

    assign acc = rx_vld & rx_rdy;
    assign ci  = tib_classify(rx_ch);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ACC;
        else     st <= st_d;
    end

    // Everything below is the next value of a registered output.
    always_comb begin
        st_d    = st;
        len_d   = len;
        ovf_d   = ovf;
        we_d    = 1'b0;
        ai_d    = mem_ai;
        vi_d    = mem_vi;
        ready_d = 1'b0;
`ifdef TIB_ECHO_EN
        tx_vld_d = 1'b0;
        tx_ch_d  = tx_ch;
`endif
        case (st)
            ACC: begin
                if (acc) begin
                    case (ci.cls)
                        CH_PUT: begin
                            if (len != LEN_MAX) begin
                                we_d  = 1'b1;
                                ai_d  = TIB_A + ASZ'(len);
                                vi_d  = MSZ'(ci.ch);
                                len_d = len + LW'(1);
`ifdef TIB_ECHO_EN
                                tx_vld_d = 1'b1;
                                tx_ch_d  = ci.ch;
`endif
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        CH_DEL: begin
                            if (len != '0) begin
                                len_d = len - LW'(1);
`ifdef TIB_ECHO_EN
                                tx_vld_d = 1'b1;
                                tx_ch_d  = ci.ch;
`endif
                            end
                        end
                        CH_EOL: begin
                            // Empty line or the LF half of CRLF is dropped.
                            if (len != '0) begin
                                st_d = TRM;
                                we_d = 1'b1;
                                ai_d = TIB_A + ASZ'(len);
                                vi_d = '0;
`ifdef TIB_ECHO_EN
                                tx_vld_d = 1'b1;
                                tx_ch_d  = ASC_CR;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            TRM: begin
                st_d    = RDY;
                ready_d = 1'b1;
`ifdef TIB_ECHO_EN
                tx_vld_d = 1'b1;
                tx_ch_d  = ASC_LF;
`endif
            end
            RDY: begin
                if (done) begin
                    st_d  = ACC;
                    len_d = '0;
                    ovf_d = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: st_d = ACC;
        endcase
        rdy_d = (st_d == ACC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= '0;
            ovf      <= 1'b0;
            ready    <= 1'b0;
            mem_we   <= 1'b0;
            mem_ai   <= TIB_A;
            mem_vi   <= '0;
            rx_rdy_q <= 1'b0;
`ifdef TIB_ECHO_EN
            tx_vld   <= 1'b0;
            tx_ch    <= '0;
`endif
        end else begin
            len      <= len_d;
            ovf      <= ovf_d;
            ready    <= ready_d;
            mem_we   <= we_d;
            mem_ai   <= ai_d;
            mem_vi   <= vi_d;
            rx_rdy_q <= rdy_d;
`ifdef TIB_ECHO_EN
            tx_vld   <= tx_vld_d;
            tx_ch    <= tx_ch_d;
`endif
        end
    end

endmodule

// File: tb/tb_tib_loader.sv
// Self-checking bench for tib_loader: queue-based line-editor model, directed
// scenarios plus randomized lines; exercises the echo path when TIB_ECHO_EN is set.
module tb_tib_loader;

    localparam int TIB    = 'h40;
    localparam int TIB_SZ = 8;
    localparam int MSZ    = 8;
    localparam int ASZ    = 17;
    localparam int LW     = $clog2(TIB_SZ);

    logic           clk = 1'b0;
    logic           rst;
    logic           rx_vld = 1'b0;
    logic [7:0]     rx_ch = 8'h00;
    logic           done = 1'b0;
    logic           rx_rdy, mem_we, ready, ovf;
    logic [ASZ-1:0] mem_ai;
    logic [MSZ-1:0] mem_vi;
    logic [LW-1:0]  len;
`ifdef TIB_ECHO_EN
    logic           tx_rdy = 1'b1;
    logic           tx_vld;
    logic [7:0]     tx_ch;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]   mem [0:(1<<ASZ)-1];
    int           wtotal = 0;
    int           wbase  = 0;
    byte unsigned txq[$];

    // Reference model: the line as a queue of characters.
    byte unsigned m_line[$];
    bit           m_ovf;
    int           m_wr;
    byte unsigned m_echo[$];

    tib_loader #(.TIB(TIB), .TIB_SZ(TIB_SZ), .MSZ(MSZ), .ASZ(ASZ)) dut (
        .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_ch(rx_ch), .rx_rdy(rx_rdy),
        .mem_we(mem_we), .mem_ai(mem_ai), .mem_vi(mem_vi), .ready(ready),
        .done(done), .len(len), .ovf(ovf)
`ifdef TIB_ECHO_EN
        , .tx_rdy(tx_rdy), .tx_vld(tx_vld), .tx_ch(tx_ch)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_ai] <= mem_vi;
            wtotal      <= wtotal + 1;
        end
    end

`ifdef TIB_ECHO_EN
    always @(posedge clk) if (tx_vld) txq.push_back(tx_ch);
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_line.delete();
        m_echo.delete();
        txq.delete();
        m_ovf = 1'b0;
        m_wr  = 0;
        wbase = wtotal;
    endtask

    // Returns 1 when the byte completes a line.
    function automatic bit model_byte(input byte unsigned b);
        byte unsigned c;
        c = (b == 8'h09) ? 8'h20 : b;
        if (b == 8'h09 || (b >= 8'h20 && b <= 8'h7e)) begin
            if (m_line.size() < TIB_SZ - 1) begin
                m_line.push_back(c);
                m_echo.push_back(c);
                m_wr++;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (b == 8'h08 || b == 8'h7f) begin
            if (m_line.size() > 0) begin
                void'(m_line.pop_back());
                m_echo.push_back(b);
            end
        end else if (b == 8'h0d || b == 8'h0a) begin
            if (m_line.size() > 0) begin
                m_echo.push_back(8'h0d);
                m_echo.push_back(8'h0a);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic byte unsigned rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 65)      return 8'($urandom_range(8'h20, 8'h7e));
        else if (r < 75) return 8'h08;
        else if (r < 79) return 8'h7f;
        else if (r < 85) return 8'h09;
        else if (r < 89) return 8'h0a;
        else             return 8'($urandom_range(0, 31));
    endfunction

    task automatic send_byte(input byte unsigned b);
        int t;
        t = 0;
        @(negedge clk);
        rx_vld = 1'b1;
        rx_ch  = b;
        done   = 1'b0;
        while (!rx_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout byte=%02h rx_rdy=%0b required 1", b, rx_rdy);
        end else begin
            @(posedge clk);
        end
    endtask

    // Terminator write, ready latency, buffer contents, hold, then done.
    task automatic end_line();
        int n;
        n = m_line.size();
        @(negedge clk);
        rx_vld = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_ai !== ASZ'(TIB + n) || mem_vi !== 8'h00) begin
            errors++;
            $display("FAIL term_write we=%0b ai=%h vi=%h required we=1 ai=%h vi=00", mem_we, mem_ai, mem_vi, ASZ'(TIB + n));
        end
        checks++;
        if (ready !== 1'b0 || rx_rdy !== 1'b0) begin
            errors++;
            $display("FAIL trm_flags ready=%0b rx_rdy=%0b required 0 0", ready, rx_rdy);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || mem_we !== 1'b0 || rx_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rdy_flags ready=%0b we=%0b rx_rdy=%0b required 1 0 0", ready, mem_we, rx_rdy);
        end
        checks++;
        if (int'(len) !== n || ovf !== m_ovf) begin
            errors++;
            $display("FAIL line_len len=%0d ovf=%0b required %0d %0b", len, ovf, n, m_ovf);
        end
        checks++;
        if (wtotal - wbase !== m_wr + 1) begin
            errors++;
            $display("FAIL write_count got=%0d required %0d", wtotal - wbase, m_wr + 1);
        end
        for (int i = 0; i <= n; i++) begin
            checks++;
            if (mem[TIB + i] !== ((i < n) ? m_line[i] : 8'h00)) begin
                errors++;
                $display("FAIL tib_byte addr=%h got=%h required %h", TIB + i, mem[TIB + i], (i < n) ? m_line[i] : 8'h00);
            end
        end
        rx_vld = 1'b1;
        rx_ch  = 8'h41;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || rx_rdy !== 1'b0 || int'(len) !== n || wtotal - wbase !== m_wr + 1) begin
            errors++;
            $display("FAIL hold ready=%0b rx_rdy=%0b len=%0d required 1 0 %0d", ready, rx_rdy, len, n);
        end
        rx_vld = 1'b0;
        done   = 1'b1;
        @(negedge clk);
        done   = 1'b0;
        checks++;
        if (ready !== 1'b0 || len !== '0 || ovf !== 1'b0 || rx_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rearm ready=%0b len=%0d ovf=%0b rx_rdy=%0b required 0 0 0 1", ready, len, ovf, rx_rdy);
        end
`ifdef TIB_ECHO_EN
        checks++;
        if (txq.size() !== m_echo.size()) begin
            errors++;
            $display("FAIL echo_count got=%0d required %0d", txq.size(), m_echo.size());
        end else begin
            for (int i = 0; i < m_echo.size(); i++) begin
                if (txq[i] !== m_echo[i]) begin
                    errors++;
                    $display("FAIL echo_byte idx=%0d got=%h required %h", i, txq[i], m_echo[i]);
                end
            end
        end
`endif
        model_clear();
    endtask

    task automatic play_seq(input byte unsigned s[$], input bit gaps);
        foreach (s[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                rx_vld = 1'b0;
                done   = 1'($urandom_range(0, 1));
                @(negedge clk);
                done   = 1'b0;
                checks++;
                if (int'(len) !== m_line.size() || ready !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_state len=%0d ready=%0b required %0d 0", len, ready, m_line.size());
                end
            end
            send_byte(s[i]);
            if (model_byte(s[i])) end_line();
        end
        @(negedge clk);
        rx_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (rx_rdy !== 1'b0 || mem_we !== 1'b0 || ready !== 1'b0 || len !== '0 || ovf !== 1'b0 ||
            mem_ai !== ASZ'(TIB) || mem_vi !== '0) begin
            errors++;
            $display("FAIL reset_vals rx_rdy=%0b we=%0b ready=%0b len=%0d ovf=%0b ai=%h vi=%h required 0 0 0 0 0 %h 00",
                     rx_rdy, mem_we, ready, len, ovf, mem_ai, mem_vi, ASZ'(TIB));
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rx_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rdy_before_edge rx_rdy=%0b required 0", rx_rdy);
        end
        @(negedge clk);
        checks++;
        if (rx_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_release rx_rdy=%0b required 1", rx_rdy);
        end
        model_clear();
    endtask

    task automatic test_basic();
        byte unsigned s[$];
        s = '{8'h31, 8'h20, 8'h32, 8'h20, 8'h2b, 8'h0d};
        play_seq(s, 1'b0);
    endtask

    task automatic test_backspace();
        byte unsigned s[$];
        s = '{8'h08, 8'h31, 8'h32, 8'h08, 8'h33, 8'h0d};
        play_seq(s, 1'b0);
    endtask

    task automatic test_overflow();
        byte unsigned s[$];
        s.delete();
        repeat (10) s.push_back(8'h41);
        s.push_back(8'h0d);
        play_seq(s, 1'b0);
    endtask

    task automatic test_empty_lines();
        byte unsigned s[$];
        s = '{8'h0d, 8'h0a, 8'h0d};
        play_seq(s, 1'b0);
        @(negedge clk);
        checks++;
        if (wtotal !== wbase || ready !== 1'b0 || rx_rdy !== 1'b1) begin
            errors++;
            $display("FAIL empty_lines writes=%0d ready=%0b rx_rdy=%0b required 0 0 1", wtotal - wbase, ready, rx_rdy);
        end
        s = '{8'h58, 8'h0d, 8'h0a};
        play_seq(s, 1'b0);
        @(negedge clk);
        checks++;
        if (wtotal !== wbase || ready !== 1'b0 || len !== '0) begin
            errors++;
            $display("FAIL trailing_lf writes=%0d ready=%0b len=%0d required 0 0 0", wtotal - wbase, ready, len);
        end
    endtask

    task automatic test_async_reset();
        byte unsigned s[$];
        s = '{8'h61, 8'h62, 8'h63};
        foreach (s[i]) send_byte(s[i]);
        @(negedge clk);
        rx_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rx_rdy !== 1'b0 || mem_we !== 1'b0 || len !== '0 || ready !== 1'b0 ||
            mem_ai !== ASZ'(TIB) || mem_vi !== '0) begin
            errors++;
            $display("FAIL async_reset rx_rdy=%0b we=%0b len=%0d ready=%0b ai=%h vi=%h required 0 0 0 0 %h 00",
                     rx_rdy, mem_we, len, ready, mem_ai, mem_vi, ASZ'(TIB));
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        s = '{8'h41, 8'h0d};
        play_seq(s, 1'b0);
    endtask

    task automatic test_random();
        byte unsigned s[$];
        for (int k = 0; k < 25; k++) begin
            s.delete();
            repeat ($urandom_range(1, 12)) s.push_back(rand_byte());
            s.push_back(8'h0d);
            play_seq(s, 1'b1);
        end
    endtask

`ifdef TIB_ECHO_EN
    task automatic test_echo();
        byte unsigned s[$];
        @(negedge clk);
        tx_rdy = 1'b0;
        rx_vld = 1'b1;
        rx_ch  = 8'h41;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_rdy !== 1'b0 || len !== '0 || wtotal !== wbase) begin
            errors++;
            $display("FAIL echo_gate rx_rdy=%0b len=%0d writes=%0d required 0 0 0", rx_rdy, len, wtotal - wbase);
        end
        rx_vld = 1'b0;
        tx_rdy = 1'b1;
        model_clear();
        s = '{8'h41, 8'h0d};
        play_seq(s, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backspace();
        test_overflow();
        test_empty_lines();
        test_async_reset();
`ifdef TIB_ECHO_EN
        test_echo();
`endif
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
